// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM state encoding and
// CPOL/CPHA mode helpers.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clkgen.sv
// SCLK timebase: a tick every div+1 clk cycles while running, plus
// leading/trailing edge strobes and the registered sclk level.
module spi_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_i,
    input  logic             run_i,
    input  logic             edge_en_i,
    input  logic             idle_lvl_i,
    output logic             tick_o,
    output logic             lead_o,
    output logic             trail_o,
    output logic             sclk_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             sclk_q;
    logic             sclk_d;
    logic             tick_s;
    logic             edge_s;

    assign tick_s  = run_i && (cnt_q == div_i);
    assign edge_s  = tick_s && edge_en_i;
    // The first edge away from the idle level is the leading one.
    assign lead_o  = edge_s && (sclk_q == idle_lvl_i);
    assign trail_o = edge_s && (sclk_q != idle_lvl_i);
    assign tick_o  = tick_s;
    assign sclk_o  = sclk_q;

    // Divider counter and sclk level next-state
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!run_i) begin
            cnt_d  = {DIV_W{1'b0}};
            sclk_d = idle_lvl_i;
        end else if (tick_s) begin
            cnt_d = {DIV_W{1'b0}};
            if (edge_s) begin
                sclk_d = ~sclk_q;
            end else begin
                sclk_d = sclk_q;
            end
        end else begin
            cnt_d  = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
            sclk_d = sclk_q;
        end
    end

    // Divider counter and sclk registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {DIV_W{1'b0}};
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Full-duplex SPI master: one transaction per accepted start, programmable
// divider, all four CPOL/CPHA modes, variable length and chip-select decode.
module spi_master
    import spi_pkg::*;
#(
    parameter int  DATA_W = 80,
    parameter int  NUM_CS = 2,
    parameter int  DIV_W  = 8,
    localparam int LEN_W  = $clog2(DATA_W + 1),
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  div,
    input  logic [LEN_W-1:0]  len,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic [NUM_CS-1:0] ss_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

    // Out-of-range selects decode to all chip selects inactive.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = {NUM_CS{1'b1}};
        for (int i = 0; i < NUM_CS; i++) begin
            if (CS_W'(i) == sel) begin
                v[i] = 1'b0;
            end else begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    spi_state_t        state_q, state_d;
    logic [1:0]        mode_q;
    logic [DIV_W-1:0]  div_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [LEN_W:0]    edge_cnt_q, edge_cnt_d;
    logic [NUM_CS-1:0] ss_n_q, ss_n_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [LEN_W-1:0]  len_eff_s;
    logic [LEN_W:0]    last_idx_s;
    logic              accept_s;
    logic              last_edge_s;
    logic              cpha_s;
    logic              run_s;
    logic              edge_en_s;
    logic              idle_lvl_s;
    logic              tick_s;
    logic              lead_s;
    logic              trail_s;
    logic              drive_s;
    logic              sample_s;

    assign len_eff_s   = (len > LEN_MAX) ? LEN_MAX : len;
    assign accept_s    = (state_q == IDLE) && start;
    assign last_idx_s  = {len_q, 1'b0} - {{LEN_W{1'b0}}, 1'b1};
    assign last_edge_s = (edge_cnt_q == last_idx_s);
    assign cpha_s      = mode_q[CPHA_BIT];
    assign run_s       = (state_q != IDLE);
    assign edge_en_s   = (state_q == XFER);
    assign idle_lvl_s  = (state_q == IDLE) ? mode[CPOL_BIT] : mode_q[CPOL_BIT];
    // CPHA=0 shifts on the trailing edge (never after the final bit);
    // CPHA=1 shifts on the leading edge and samples on the trailing one.
    assign drive_s     = cpha_s ? lead_s : (trail_s && !last_edge_s);
    assign sample_s    = cpha_s ? trail_s : lead_s;

    spi_clkgen #(
        .DIV_W(DIV_W)
    ) u_clkgen (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_i     (div_q),
        .run_i     (run_s),
        .edge_en_i (edge_en_s),
        .idle_lvl_i(idle_lvl_s),
        .tick_o    (tick_s),
        .lead_o    (lead_s),
        .trail_o   (trail_s),
        .sclk_o    (sclk)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s && (len_eff_s != {LEN_W{1'b0}})) begin
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (tick_s) begin
                    state_d = XFER;
                end else begin
                    state_d = SETUP;
                end
            end
            XFER: begin
                if (tick_s && last_edge_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = XFER;
                end
            end
            HOLD: begin
                if (tick_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM output next-values for the pin and handshake registers
    always_comb begin
        ss_n_d = ss_n_q;
        mosi_d = mosi_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                ss_n_d = {NUM_CS{1'b1}};
                mosi_d = 1'b1;
                busy_d = 1'b0;
                if (accept_s && (len_eff_s != {LEN_W{1'b0}})) begin
                    ss_n_d = cs_decode(cs_sel);
                    busy_d = 1'b1;
                    if (mode[CPHA_BIT]) begin
                        mosi_d = 1'b1;
                    end else begin
                        mosi_d = tx_data[DATA_W-1];
                    end
                end else if (accept_s) begin
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            SETUP: begin
                ss_n_d = ss_n_q;
            end
            XFER: begin
                if (drive_s) begin
                    mosi_d = tx_q[DATA_W-1];
                end else begin
                    mosi_d = mosi_q;
                end
            end
            HOLD: begin
                if (tick_s) begin
                    ss_n_d = {NUM_CS{1'b1}};
                    mosi_d = 1'b1;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            default: begin
                ss_n_d = {NUM_CS{1'b1}};
                mosi_d = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    // Shift registers and edge counter next-state
    always_comb begin
        tx_d       = tx_q;
        rx_d       = rx_q;
        edge_cnt_d = edge_cnt_q;
        if (accept_s) begin
            rx_d       = {DATA_W{1'b0}};
            edge_cnt_d = {(LEN_W+1){1'b0}};
            if (mode[CPHA_BIT]) begin
                tx_d = tx_data;
            end else begin
                tx_d = {tx_data[DATA_W-2:0], 1'b0};
            end
        end else if (edge_en_s && tick_s) begin
            edge_cnt_d = edge_cnt_q + {{LEN_W{1'b0}}, 1'b1};
            if (drive_s) begin
                tx_d = {tx_q[DATA_W-2:0], 1'b0};
            end else begin
                tx_d = tx_q;
            end
            if (sample_s) begin
                rx_d = {rx_q[DATA_W-2:0], miso};
            end else begin
                rx_d = rx_q;
            end
        end else begin
            edge_cnt_d = edge_cnt_q;
        end
    end

    // Transaction configuration latched on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= SPI_MODE0;
            div_q  <= {DIV_W{1'b0}};
            len_q  <= {LEN_W{1'b0}};
        end else if (accept_s) begin
            mode_q <= mode;
            div_q  <= div;
            len_q  <= len_eff_s;
        end else begin
            mode_q <= mode_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q       <= {DATA_W{1'b0}};
            rx_q       <= {DATA_W{1'b0}};
            edge_cnt_q <= {(LEN_W+1){1'b0}};
            ss_n_q     <= {NUM_CS{1'b1}};
            mosi_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            edge_cnt_q <= edge_cnt_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rx_data = rx_q;
    assign ss_n    = ss_n_q;
    assign mosi    = mosi_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master with a behavioural SPI slave.
module tb_spi_master;

    localparam int DATA_W = 80;
    localparam int NUM_CS = 2;
    localparam int DIV_W  = 8;
    localparam int LEN_W  = 7;
    localparam int CS_W   = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  div;
    logic [LEN_W-1:0]  len;
    logic [CS_W-1:0]   cs_sel;
    logic [DATA_W-1:0] tx_data;
    logic              busy, done, sclk, mosi, miso;
    logic [DATA_W-1:0] rx_data;
    logic [NUM_CS-1:0] ss_n;

    int n_checks = 0;
    int n_errors = 0;

    // slave model: kind 0 shifts out s_resp, 1 loops mosi back, 2 inverts mosi
    int                s_kind = 0;
    int                s_len  = 8;
    logic [DATA_W-1:0] s_resp = '0;
    logic              s_cpol = 1'b0;
    logic              s_cpha = 1'b0;
    logic [DATA_W-1:0] s_rx   = '0;
    logic              s_miso = 1'b0;
    int                s_bit  = 0;
    int                sclk_edges = 0;
    logic              prev_ss = 1'b1;
    logic              prev_sclk = 1'b0;

    spi_master #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .div(div),
        .len(len), .cs_sel(cs_sel), .tx_data(tx_data), .busy(busy),
        .done(done), .rx_data(rx_data), .ss_n(ss_n), .sclk(sclk),
        .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    assign miso = (s_kind == 1) ? mosi : ((s_kind == 2) ? ~mosi : s_miso);

    always @(sclk or ss_n[0]) begin
        if (ss_n[0] !== prev_ss && ss_n[0] === 1'b0) begin
            s_bit = 0;
            s_rx  = '0;
            if (!s_cpha && s_len > 0) s_miso = s_resp[s_len-1];
        end
        if (sclk !== prev_sclk) begin
            sclk_edges = sclk_edges + 1;
            if (ss_n[0] === 1'b0) begin
                if (sclk !== s_cpol) begin
                    if (!s_cpha) s_rx = {s_rx[DATA_W-2:0], mosi};
                    else if (s_bit < s_len) s_miso = s_resp[s_len-1-s_bit];
                end else begin
                    if (!s_cpha) begin
                        s_bit = s_bit + 1;
                        if (s_bit < s_len) s_miso = s_resp[s_len-1-s_bit];
                    end else begin
                        s_rx  = {s_rx[DATA_W-2:0], mosi};
                        s_bit = s_bit + 1;
                    end
                end
            end
        end
        prev_ss   = ss_n[0];
        prev_sclk = sclk;
    end

    task automatic prep(input logic [1:0] m);
        @(negedge clk);
        mode = m;
        repeat (2) @(negedge clk);
    endtask

    task automatic launch(input logic [1:0] m, input logic [DIV_W-1:0] d, input logic [LEN_W-1:0] l,
                          input logic [CS_W-1:0] c, input logic [DATA_W-1:0] t);
        mode = m; div = d; len = l; cs_sel = c; tx_data = t; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int limit, output int cyc,
                             output logic [DATA_W-1:0] rx, output logic [NUM_CS-1:0] low_mask);
        cyc = c0;
        low_mask = '0;
        while (done !== 1'b1 && cyc < limit) begin
            low_mask = low_mask | ~ss_n;
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) cyc = -1;
        rx = rx_data;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; mode = 2'b10; div = '0; len = '0; cs_sel = '0; tx_data = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (ss_n !== 2'b11) begin n_errors++; $display("FAIL reset_ss_n: got %b want 11", ss_n); end
        n_checks++; if (sclk !== 1'b0) begin n_errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        n_checks++; if (mosi !== 1'b1) begin n_errors++; $display("FAIL reset_mosi: got %b want 1", mosi); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (rx_data !== '0) begin n_errors++; $display("FAIL reset_rx: got %h want 0", rx_data); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (sclk !== 1'b1) begin n_errors++; $display("FAIL idle_sclk_cpol1: got %b want 1", sclk); end
    endtask

    task automatic test_mode0;
        int cyc, e0;
        logic [DATA_W-1:0] rx;
        logic [NUM_CS-1:0] lm;
        prep(2'b00);
        s_kind = 0; s_resp = 80'h3C; s_len = 8; s_cpol = 1'b0; s_cpha = 1'b0;
        e0 = sclk_edges;
        launch(2'b00, 8'd0, 7'd8, 1'b0, {8'hA5, 72'h0});
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL mode0_busy_c1: got %b want 1", busy); end
        wait_done(1, 200, cyc, rx, lm);
        n_checks++; if (cyc !== 19) begin n_errors++; $display("FAIL mode0_done_cycle: got %0d want 19", cyc); end
        n_checks++; if (rx !== 80'h3C) begin n_errors++; $display("FAIL mode0_rx: got %h want 3c", rx); end
        n_checks++; if (s_rx !== 80'hA5) begin n_errors++; $display("FAIL mode0_mosi_bits: got %h want a5", s_rx); end
        n_checks++; if (lm !== 2'b01) begin n_errors++; $display("FAIL mode0_ss_mask: got %b want 01", lm); end
        n_checks++; if (sclk_edges - e0 !== 16) begin n_errors++; $display("FAIL mode0_edges: got %0d want 16", sclk_edges - e0); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mode0_busy_done: got %b want 0", busy); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL mode0_done_pulse: got %b want 0", done); end
        n_checks++; if (mosi !== 1'b1 || sclk !== 1'b0) begin n_errors++; $display("FAIL mode0_idle_pins: got mosi=%b sclk=%b want 1,0", mosi, sclk); end
    endtask

    task automatic test_modes123;
        int cyc, e0;
        logic [DATA_W-1:0] rx;
        logic [NUM_CS-1:0] lm;
        logic [1:0] m;
        for (int i = 1; i < 4; i++) begin
            m = 2'(i);
            prep(m);
            n_checks++; if (sclk !== m[1]) begin n_errors++; $display("FAIL mode%0d_idle_pre: got %b want %b", i, sclk, m[1]); end
            s_kind = 1; s_len = 16; s_cpol = m[1]; s_cpha = m[0];
            e0 = sclk_edges;
            launch(m, 8'd3, 7'd16, 1'b0, {16'hBEEF, 64'h0});
            wait_done(1, 400, cyc, rx, lm);
            n_checks++; if (cyc !== 137) begin n_errors++; $display("FAIL mode%0d_done_cycle: got %0d want 137", i, cyc); end
            n_checks++; if (rx !== 80'hBEEF) begin n_errors++; $display("FAIL mode%0d_rx: got %h want beef", i, rx); end
            n_checks++; if (s_rx !== 80'hBEEF) begin n_errors++; $display("FAIL mode%0d_mosi_bits: got %h want beef", i, s_rx); end
            n_checks++; if (sclk_edges - e0 !== 32) begin n_errors++; $display("FAIL mode%0d_edges: got %0d want 32", i, sclk_edges - e0); end
            @(negedge clk);
            n_checks++; if (sclk !== m[1]) begin n_errors++; $display("FAIL mode%0d_idle_post: got %b want %b", i, sclk, m[1]); end
        end
    endtask

    task automatic test_len0;
        int cyc, e0;
        logic [DATA_W-1:0] rx;
        logic [NUM_CS-1:0] lm;
        prep(2'b00);
        s_kind = 0; s_resp = '1; s_len = 8; s_cpol = 1'b0; s_cpha = 1'b0;
        e0 = sclk_edges;
        launch(2'b00, 8'd0, 7'd0, 1'b0, '1);
        wait_done(1, 20, cyc, rx, lm);
        n_checks++; if (cyc !== 1) begin n_errors++; $display("FAIL len0_done_cycle: got %0d want 1", cyc); end
        n_checks++; if (rx !== '0) begin n_errors++; $display("FAIL len0_rx: got %h want 0", rx); end
        n_checks++; if (lm !== 2'b00) begin n_errors++; $display("FAIL len0_ss_mask: got %b want 00", lm); end
        repeat (5) @(negedge clk);
        n_checks++; if (sclk_edges - e0 !== 0) begin n_errors++; $display("FAIL len0_edges: got %0d want 0", sclk_edges - e0); end
    endtask

    task automatic test_len_max;
        int cyc, e0;
        logic [DATA_W-1:0] rx;
        logic [NUM_CS-1:0] lm;
        logic [LEN_W-1:0] lens [2];
        lens[0] = 7'd80; lens[1] = 7'd100;
        for (int k = 0; k < 2; k++) begin
            prep(2'b00);
            s_kind = 2; s_len = 80; s_cpol = 1'b0; s_cpha = 1'b0;
            e0 = sclk_edges;
            launch(2'b00, 8'd1, lens[k], 1'b0, '1);
            wait_done(1, 1000, cyc, rx, lm);
            n_checks++; if (cyc !== 325) begin n_errors++; $display("FAIL len%0d_done_cycle: got %0d want 325", lens[k], cyc); end
            n_checks++; if (rx !== '0) begin n_errors++; $display("FAIL len%0d_rx: got %h want 0", lens[k], rx); end
            n_checks++; if (s_rx !== {DATA_W{1'b1}}) begin n_errors++; $display("FAIL len%0d_mosi_bits: got %h want all ones", lens[k], s_rx); end
            n_checks++; if (sclk_edges - e0 !== 160) begin n_errors++; $display("FAIL len%0d_edges: got %0d want 160", lens[k], sclk_edges - e0); end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [DATA_W-1:0] rx;
        logic [NUM_CS-1:0] lm;
        prep(2'b00);
        s_kind = 0; s_resp = 80'h55; s_len = 8; s_cpol = 1'b0; s_cpha = 1'b0;
        launch(2'b00, 8'd0, 7'd8, 1'b0, {8'h81, 72'h0});
        repeat (4) @(negedge clk);
        mode = 2'b11; div = 8'd5; len = 7'd4; tx_data = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, 200, cyc, rx, lm);
        n_checks++; if (cyc !== 19) begin n_errors++; $display("FAIL b2b_first_done: got %0d want 19", cyc); end
        n_checks++; if (rx !== 80'h55) begin n_errors++; $display("FAIL b2b_first_rx: got %h want 55", rx); end
        n_checks++; if (s_rx !== 80'h81) begin n_errors++; $display("FAIL b2b_first_mosi: got %h want 81", s_rx); end
        n_checks++; if (ss_n !== 2'b11) begin n_errors++; $display("FAIL b2b_ss_gap: got %b want 11", ss_n); end
        s_resp = 80'hA; s_len = 4;
        launch(2'b00, 8'd0, 7'd4, 1'b0, {4'hC, 76'h0});
        n_checks++; if (ss_n !== 2'b10) begin n_errors++; $display("FAIL b2b_second_ss: got %b want 10", ss_n); end
        wait_done(1, 100, cyc, rx, lm);
        n_checks++; if (cyc !== 11) begin n_errors++; $display("FAIL b2b_second_done: got %0d want 11", cyc); end
        n_checks++; if (rx !== 80'hA) begin n_errors++; $display("FAIL b2b_second_rx: got %h want a", rx); end
        n_checks++; if (s_rx !== 80'hC) begin n_errors++; $display("FAIL b2b_second_mosi: got %h want c", s_rx); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        int seen;
        logic [DATA_W-1:0] rx;
        logic [NUM_CS-1:0] lm;
        prep(2'b00);
        s_kind = 0; s_resp = 80'h96; s_len = 8; s_cpol = 1'b0; s_cpha = 1'b0;
        launch(2'b00, 8'd0, 7'd8, 1'b0, {8'h00, 72'h0});
        repeat (12) @(negedge clk);
        n_checks++; if (ss_n !== 2'b10 || sclk !== 1'b1 || mosi !== 1'b0) begin
            n_errors++; $display("FAIL midxfer_state: got ss_n=%b sclk=%b mosi=%b want 10,1,0", ss_n, sclk, mosi); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (ss_n !== 2'b11) begin n_errors++; $display("FAIL abort_ss_n: got %b want 11", ss_n); end
        n_checks++; if (sclk !== 1'b0) begin n_errors++; $display("FAIL abort_sclk: got %b want 0", sclk); end
        n_checks++; if (mosi !== 1'b1) begin n_errors++; $display("FAIL abort_mosi: got %b want 1", mosi); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (rx_data !== '0) begin n_errors++; $display("FAIL abort_rx: got %h want 0", rx_data); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        prep(2'b00);
        s_resp = 80'h69;
        launch(2'b00, 8'd0, 7'd8, 1'b0, {8'h3A, 72'h0});
        wait_done(1, 200, cyc, rx, lm);
        n_checks++; if (cyc !== 19) begin n_errors++; $display("FAIL after_abort_done: got %0d want 19", cyc); end
        n_checks++; if (rx !== 80'h69) begin n_errors++; $display("FAIL after_abort_rx: got %h want 69", rx); end
        n_checks++; if (s_rx !== 80'h3A) begin n_errors++; $display("FAIL after_abort_mosi: got %h want 3a", s_rx); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes123();
        test_len0();
        test_len_max();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
